seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Time-multiplexed driver for an N-digit common-select 7-segment display.
//   Takes per-digit logical patterns {A,B,C,D,E,F,G,DP}, double-buffers them via valid/ready,
//   scans one digit at a time with anti-ghost blanking and PWM brightness.
//   Sits between the display-content logic and the board-level pin remap.
// PARAMETERS
//   NUM_DIGITS     4     digits scanned (>=1)
//   SCAN_DIV       1000  clocks each digit is selected per frame (> BLANK_CYC)
//   BLANK_CYC      16    clocks at start of each dwell with all selects inactive (>=1)
//   PWM_BITS       4     brightness resolution
//   SEL_ACTIVE_LOW 1     1: asserted select = 0
//   SEG_ACTIVE_LOW 1     1: lit segment = 0
// PORTS
//   clk          in   1             system clock
//   rst_n        in   1             asynchronous active-low reset
//   en           in   1             1 = scanning, 0 = display dark
//   upd_valid    in   1             new frame data offered
//   upd_ready    out  1             pending buffer can accept
//   upd_data     in   NUM_DIGITS*8  digit k at [8k+7:8k], bit7=A ... bit1=G, bit0=DP, 1=lit
//   bright       in   PWM_BITS      duty level, sampled every clock
//   sel          out  NUM_DIGITS    digit selects, polarity per SEL_ACTIVE_LOW
//   seg          out  8             {A,B,C,D,E,F,G,DP}, polarity per SEG_ACTIVE_LOW
//   frame_start  out  1             one-clock pulse when digit 0 dwell begins
// BEHAVIOUR
//   Reset (async, rst_n=0): sel/seg inactive level, frame_start=0, upd_ready=1,
//     digit_idx=0, dwell_cnt=0, pwm_cnt=0, active/pending buffers=0, pending_full=0.
//   Counters (en=1): dwell_cnt 0..SCAN_DIV-1, wraps and advances digit_idx
//     0..NUM_DIGITS-1 (wraps to 0); pwm_cnt free-running modulo 2^PWM_BITS.
//   en=0: dwell_cnt, digit_idx, pwm_cnt held at 0; sel/seg inactive next clock;
//     no frame_start. Buffer handshake still works. en rising restarts at digit 0 with frame_start.
//   Handshake: upd_ready = !pending_full. Accept on upd_valid&&upd_ready: pending<=upd_data,
//     pending_full<=1. Data held until accepted; no drop, no overwrite.
//   Swap: at frame boundary (digit_idx=0, dwell_cnt=0, en=1), if pending_full:
//     active<=pending, pending_full<=0. Same cycle: frame_start=1 (registered, visible next clk).
//     Accept on the boundary cycle impossible (ready low if full); accept while empty on
//     boundary cycle waits for next frame.
//   Output phase per dwell: dwell_cnt<BLANK_CYC -> all sel inactive, seg inactive.
//     Otherwise lit = (bright==all ones) || (pwm_cnt<bright); lit -> sel[digit_idx] active,
//     others inactive, seg=active[digit_idx] with polarity; not lit -> all inactive.
//     bright=0 -> always dark.
//   Latency: sel/seg/frame_start registered, one clock after the counter state that selects them.
//   Never more than one sel bit asserted; no glitch between digits (blank covers change).
// TESTING (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, PWM_BITS=2, both ACTIVE_LOW=1)
//   Reset mid-scan -> sel=4'b1111, seg=8'hFF immediately; upd_ready=1; first frame_start 1 clk after release.
//   upd_data=32'h60DAF2FC, bright=3 -> digit0 dwell seg=~8'hFC, sel=4'b1110 for 6 of 8 clks; order 0,1,2,3.
//   bright=1 -> lit 1 of 4 clks in lit phase; bright=0 -> sel stays 4'b1111 all frame.
//   Two back-to-back upd_valid mid-frame -> first accepted, ready low, second held; swap at boundary, second accepted next clk.
//   en low for 20 clks mid-frame -> outputs inactive 1 clk later; en high -> frame_start, digit 0 restarts.
//   Random valid/data/bright for 10k clks -> scoreboard: onehot-or-zero sel, frames atomic, no lost update.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with a double-buffered frame,
// anti-ghost blanking at the start of every dwell and PWM brightness.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 16,
  parameter int PWM_BITS       = 4,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [NUM_DIGITS*8-1:0] upd_data,
  input  logic [PWM_BITS-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              seg,
  output logic                    frame_start
);

  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DIG_W-1:0]      LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
  localparam logic [DWELL_W-1:0]    LAST_DWELL = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DWELL_W-1:0]    BLANK_END  = DWELL_W'(BLANK_CYC);
  localparam logic [PWM_BITS-1:0]   PWM_FULL   = {PWM_BITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                       : {NUM_DIGITS{1'b0}};
  localparam logic [7:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [DIG_W-1:0]        digit_idx_r;
  logic [DWELL_W-1:0]      dwell_cnt_r;
  logic [PWM_BITS-1:0]     pwm_cnt_r;
  logic [NUM_DIGITS*8-1:0] active_r;
  logic [NUM_DIGITS*8-1:0] pending_r;
  logic                    pending_full_r;
  logic [NUM_DIGITS-1:0]   sel_r;
  logic [7:0]              seg_r;
  logic                    frame_start_r;

  logic [DIG_W-1:0]        digit_idx_nxt_s;
  logic [DWELL_W-1:0]      dwell_cnt_nxt_s;
  logic [PWM_BITS-1:0]     pwm_cnt_nxt_s;
  logic                    boundary_s;
  logic                    accept_s;
  logic                    swap_s;
  logic                    lit_s;
  logic [7:0]              digit_pat_s;
  logic [NUM_DIGITS-1:0]   sel_onehot_s;
  logic [NUM_DIGITS-1:0]   sel_nxt_s;
  logic [7:0]              seg_nxt_s;

  assign upd_ready   = ~pending_full_r;
  assign sel         = sel_r;
  assign seg         = seg_r;
  assign frame_start = frame_start_r;

  // Scan counter next state; everything parks at zero while disabled.
  always_comb begin
    digit_idx_nxt_s = digit_idx_r;
    dwell_cnt_nxt_s = dwell_cnt_r;
    pwm_cnt_nxt_s   = pwm_cnt_r;
    if (!en) begin
      digit_idx_nxt_s = {DIG_W{1'b0}};
      dwell_cnt_nxt_s = {DWELL_W{1'b0}};
      pwm_cnt_nxt_s   = {PWM_BITS{1'b0}};
    end else begin
      pwm_cnt_nxt_s = pwm_cnt_r + PWM_BITS'(1);
      if (dwell_cnt_r == LAST_DWELL) begin
        dwell_cnt_nxt_s = {DWELL_W{1'b0}};
        if (digit_idx_r == LAST_DIGIT) begin
          digit_idx_nxt_s = {DIG_W{1'b0}};
        end else begin
          digit_idx_nxt_s = digit_idx_r + DIG_W'(1);
        end
      end else begin
        dwell_cnt_nxt_s = dwell_cnt_r + DWELL_W'(1);
      end
    end
  end

  // Handshake and frame-boundary swap; accept and swap are mutually exclusive
  // because accept needs an empty pending buffer and swap needs a full one.
  always_comb begin
    boundary_s = en && (digit_idx_r == {DIG_W{1'b0}}) && (dwell_cnt_r == {DWELL_W{1'b0}});
    accept_s   = upd_valid && !pending_full_r;
    swap_s     = boundary_s && pending_full_r;
  end

  // Output phase: blank window first, then PWM-gated drive of the current digit.
  always_comb begin
    sel_nxt_s    = SEL_OFF;
    seg_nxt_s    = SEG_OFF;
    digit_pat_s  = active_r[{digit_idx_r, 3'b000} +: 8];
    sel_onehot_s = NUM_DIGITS'(1'b1) << digit_idx_r;
    lit_s        = en && (dwell_cnt_r >= BLANK_END) &&
                   ((bright == PWM_FULL) || (pwm_cnt_r < bright));
    if (lit_s) begin
      sel_nxt_s = (SEL_ACTIVE_LOW != 0) ? ~sel_onehot_s : sel_onehot_s;
      seg_nxt_s = (SEG_ACTIVE_LOW != 0) ? ~digit_pat_s : digit_pat_s;
    end else begin
      sel_nxt_s = SEL_OFF;
      seg_nxt_s = SEG_OFF;
    end
  end

  // Scan counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx_r <= {DIG_W{1'b0}};
      dwell_cnt_r <= {DWELL_W{1'b0}};
      pwm_cnt_r   <= {PWM_BITS{1'b0}};
    end else begin
      digit_idx_r <= digit_idx_nxt_s;
      dwell_cnt_r <= dwell_cnt_nxt_s;
      pwm_cnt_r   <= pwm_cnt_nxt_s;
    end
  end

  // Pending/active double buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r       <= {(NUM_DIGITS*8){1'b0}};
      pending_r      <= {(NUM_DIGITS*8){1'b0}};
      pending_full_r <= 1'b0;
    end else if (accept_s) begin
      pending_r      <= upd_data;
      pending_full_r <= 1'b1;
    end else if (swap_s) begin
      active_r       <= pending_r;
      pending_full_r <= 1'b0;
    end else begin
      pending_full_r <= pending_full_r;
    end
  end

  // Registered pin-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r         <= SEL_OFF;
      seg_r         <= SEG_OFF;
      frame_start_r <= 1'b0;
    end else begin
      sel_r         <= sel_nxt_s;
      seg_r         <= seg_nxt_s;
      frame_start_r <= boundary_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 8-clock dwell, 2-clock blank,
// 2-bit PWM, active-low selects and segments.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_data;
  logic [1:0]  bright;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Expected-state tracking: kk is the scan position (dwell clocks since the
  // last restart); act_exp / pend_* hold the expected buffer contents.
  int          kk;
  logic [31:0] act_exp;
  logic [31:0] pend_data_exp;
  logic        pend_exp;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .PWM_BITS(2),
    .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .bright(bright), .sel(sel), .seg(seg), .frame_start(frame_start)
  );

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, kk, obs, expv);
    end
  endtask

  // One clock: predict outputs from the pre-edge scan position and inputs, then compare.
  task automatic step(input string tag);
    int          dc;
    int          d;
    logic        lit;
    logic        e_en;
    logic [3:0]  esel;
    logic [7:0]  eseg;
    logic        efs;
    logic        acc;
    logic        sw;
    logic [31:0] dv;
    dc   = kk % 8;
    d    = (kk / 8) % 4;
    e_en = en;
    dv   = upd_data;
    lit  = e_en && (dc >= 2) && ((bright == 2'd3) || ((kk % 4) < int'(bright)));
    esel = lit ? ~(4'b0001 << d) : 4'hF;
    eseg = lit ? ~act_exp[d*8 +: 8] : 8'hFF;
    efs  = e_en && ((kk % 32) == 0);
    acc  = upd_valid && !pend_exp;
    sw   = e_en && ((kk % 32) == 0) && pend_exp;
    @(posedge clk);
    #1;
    if (acc) begin
      pend_data_exp = dv;
      pend_exp      = 1'b1;
    end else if (sw) begin
      act_exp  = pend_data_exp;
      pend_exp = 1'b0;
    end
    check1({tag, ".sel"}, 32'(sel), 32'(esel));
    check1({tag, ".seg"}, 32'(seg), 32'(eseg));
    check1({tag, ".fs"}, 32'(frame_start), 32'(efs));
    check1({tag, ".rdy"}, 32'(upd_ready), 32'(!pend_exp));
    check1({tag, ".onehot"}, 32'($countones(~sel) <= 1), 32'(1));
    kk = e_en ? kk + 1 : 0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; upd_valid = 1'b0; upd_data = 32'h0; bright = 2'd3;
    kk = 0; act_exp = 32'h0; pend_data_exp = 32'h0; pend_exp = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("rst.sel", 32'(sel), 32'h0000000F);
    check1("rst.seg", 32'(seg), 32'h000000FF);
    check1("rst.rdy", 32'(upd_ready), 32'h1);
    check1("rst.fs", 32'(frame_start), 32'h0);

    // Load a frame while dark, then enable: swap lands on the first boundary
    rst_n = 1'b1;
    upd_valid = 1'b1; upd_data = 32'h60DAF2FC;
    step("load");
    check1("load.rdy_low", 32'(upd_ready), 32'h0);
    upd_valid = 1'b0;
    repeat (2) step("dark");
    en = 1'b1;
    repeat (3) step("b3");
    check1("dig0.sel", 32'(sel), 32'h0000000E);
    check1("dig0.seg", 32'(seg), 32'h00000003);
    repeat (29) step("b3");

    // Dimmer levels
    bright = 2'd1;
    repeat (32) step("b1");
    bright = 2'd0;
    repeat (32) step("b0");

    // Back-to-back offers mid-frame: first taken, second held until the swap frees the buffer
    bright = 2'd3;
    repeat (4) step("pre_hs");
    upd_valid = 1'b1; upd_data = 32'h3F065B4F;
    step("hs1");
    check1("hs1.rdy", 32'(upd_ready), 32'h0);
    upd_data = 32'h667D077F;
    while ((kk % 32) != 0) step("hs_hold");
    step("hs_swap");
    check1("hs_swap.rdy", 32'(upd_ready), 32'h1);
    step("hs2");
    check1("hs2.rdy", 32'(upd_ready), 32'h0);
    upd_valid = 1'b0;
    repeat (30) step("hs_f1");
    repeat (32) step("hs_f2");

    // Disable for 20 clocks mid-frame, then restart at digit 0
    repeat (11) step("pre_en");
    en = 1'b0;
    step("en_off");
    check1("en_off.sel", 32'(sel), 32'h0000000F);
    repeat (19) step("en_low");
    en = 1'b1;
    step("en_on");
    check1("en_on.fs", 32'(frame_start), 32'h1);
    repeat (31) step("en_run");

    // Short randomized run against the same expectations
    repeat (400) begin
      upd_valid = 1'($urandom_range(0, 1));
      upd_data  = $urandom;
      bright    = 2'($urandom_range(0, 3));
      en        = 1'($urandom_range(0, 19) != 0);
      step("rnd");
    end

    // Reset asserted mid-scan acts immediately
    upd_valid = 1'b0; en = 1'b1; bright = 2'd3;
    repeat (5) step("pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    check1("mid_rst.sel", 32'(sel), 32'h0000000F);
    check1("mid_rst.seg", 32'(seg), 32'h000000FF);
    check1("mid_rst.rdy", 32'(upd_ready), 32'h1);
    check1("mid_rst.fs", 32'(frame_start), 32'h0);
    kk = 0; act_exp = 32'h0; pend_exp = 1'b0; pend_data_exp = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst");
    check1("post_rst.fs1", 32'(frame_start), 32'h1);
    repeat (10) step("post_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
